// File: rtl/loopback_rd_reorder.sv
// Reorders tagged read responses into request order on a valid/ready stream; 2-cycle latency from head response to out_valid.
// Responses are never backpressured; requests stall via req_ready when all slots are allocated.
module loopback_rd_reorder #(
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [TAG_WIDTH-1:0]  req_tag,
    input  logic                  rsp_valid,
    input  logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [TAG_WIDTH:0]    outstanding,
    output logic                  err
);
    localparam int DEPTH = 1 << TAG_WIDTH;

    logic [TAG_WIDTH-1:0]  alloc_ptr;
    logic [TAG_WIDTH-1:0]  head_ptr;
    logic [TAG_WIDTH:0]    count;
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      filled;
    logic [DEPTH-1:0]      pending_nxt;
    logic [DEPTH-1:0]      filled_nxt;
    logic [DATA_WIDTH-1:0] store [DEPTH];

    logic alloc;
    logic rsp_ok;
    logic drain;

    assign req_ready   = count < (TAG_WIDTH+1)'(DEPTH);
    assign req_tag     = alloc_ptr;
    assign outstanding = count;

    assign alloc  = req_valid && req_ready;
    // A response only lands in a slot allocated in an earlier cycle and not yet filled.
    assign rsp_ok = rsp_valid && pending[rsp_tag] && !filled[rsp_tag];
    assign drain  = filled[head_ptr] && (!out_valid || out_ready);

    always_comb begin
        pending_nxt = pending;
        filled_nxt  = filled;
        if (alloc) begin
            pending_nxt[alloc_ptr] = 1'b1;
            filled_nxt[alloc_ptr]  = 1'b0;
        end
        if (rsp_ok) begin
            filled_nxt[rsp_tag] = 1'b1;
        end
        if (drain) begin
            pending_nxt[head_ptr] = 1'b0;
            filled_nxt[head_ptr]  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr <= '0;
            head_ptr  <= '0;
            count     <= '0;
            pending   <= '0;
            filled    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            pending <= pending_nxt;
            filled  <= filled_nxt;
            if (alloc) begin
                alloc_ptr <= alloc_ptr + 1'b1;
            end
            if (drain) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({alloc, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rsp_valid && !rsp_ok) begin
                err <= 1'b1;
            end
            if (drain) begin
                out_valid <= 1'b1;
                out_data  <= store[head_ptr];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Payload store carries no reset; slot validity lives entirely in pending/filled.
    always_ff @(posedge clk) begin
        if (rsp_ok) begin
            store[rsp_tag] <= rsp_data;
        end
    end
endmodule

// File: doc/loopback_rd_reorder.md
# loopback_rd_reorder

Read-response reorder stage that sits directly upstream of the loopback engine's read-response capture. It allocates tags for outgoing read requests in issue order, accepts memory read responses that may return out of order, and delivers the data strictly in request order on a valid/ready stream. Downstream FIFO enqueue logic can therefore rely on response order matching its descending-offset request order.

## Interface
- DATA_WIDTH, 512, width of one cache-line payload
- TAG_WIDTH, 6, tag width; DEPTH = 2**TAG_WIDTH outstanding slots (default 64)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  requester issues one read this cycle
- req_ready  out  1  a slot is free; issue accepted iff req_valid && req_ready
- req_tag  out  TAG_WIDTH  tag to attach to the issued read (current allocation pointer)
- rsp_valid  in  1  memory read response valid (no backpressure)
- rsp_tag  in  TAG_WIDTH  tag of response
- rsp_data  in  DATA_WIDTH  response payload
- out_valid  out  1  in-order data valid
- out_data  out  DATA_WIDTH  in-order payload
- out_ready  in  1  consumer accepts out_data
- outstanding  out  TAG_WIDTH+1  slots allocated and not yet drained to output register
- err  out  1  sticky protocol error

## Operation
- State: alloc_ptr, head_ptr (TAG_WIDTH bits, wrap modulo DEPTH), count (TAG_WIDTH+1 bits), per-slot pending and filled bits, DEPTH x DATA_WIDTH data store, one output register.
- Allocate: on req_valid && req_ready, slot alloc_ptr: pending<=1, filled<=0; alloc_ptr<=alloc_ptr+1 (DEPTH-1 wraps to 0). req_tag = alloc_ptr combinationally.
- req_ready = (count < DEPTH).
- Response: if rsp_valid and slot rsp_tag is pending and not filled: store rsp_data, filled<=1. Otherwise drop the response and set err<=1 (remains set until reset).
- Drain: when slot head_ptr is filled and (!out_valid || out_ready): load out_data from store, out_valid<=1, clear pending/filled of head slot, head_ptr<=head_ptr+1, count decrements.
- When out_valid && out_ready and no drain occurs: out_valid<=0.
- Simultaneous allocate and drain: count unchanged. Allocate into a slot freed in the same cycle is impossible (count < DEPTH gating); allocate and response in the same cycle to different slots are both honoured.
- Response arriving in the same cycle its slot is allocated: treated as error (slot is not yet pending).
- Reset values: req_ready=1, req_tag=0, out_valid=0, out_data=0, outstanding=0, err=0; all pending/filled bits cleared, both pointers 0.
- Reset mid-operation: all in-flight slots are discarded; late responses after reset hit non-pending slots and set err. Callers must quiesce memory before resetting.

## Timing
- Response accepted in cycle N for the head slot with empty output register: out_valid=1 in cycle N+2.
- Full-rate streaming: with responses in order and out_ready held high, one out_data per cycle after the initial 2-cycle latency.
- Output register holds out_data stable while out_valid && !out_ready.
- req_ready deasserts in the cycle after count reaches DEPTH; reasserts the cycle after the first drain.
- err asserts the cycle after the offending rsp_valid.
- outstanding equals count, registered.

## Test plan
- In-order: 8 requests tags 0..7, responses tags 0..7 with data 0x100+tag, out_ready=1 -> out_data 0x100..0x107 in order, first out_valid 2 cycles after rsp for tag 0, err=0.
- Reverse order: 64 requests (fill), responses tags 63 down to 0 -> req_ready=0 after 64th issue; no out_valid until tag 0 returns; then 64 consecutive beats in tag order 0..63; outstanding returns to 0.
- Backpressure/wrap: 100 requests with random response order within a 64-slot window and out_ready toggling 50% -> all 100 beats in order, out_data stable while stalled, tags wrap 63->0, no beat lost or duplicated.
- Simultaneous: at count=DEPTH, drain and req_valid in same cycle -> allocate accepted the cycle after req_ready rises, count stays consistent; allocate and response to another tag same cycle both take effect.
- Error: response to unallocated tag 5 at idle, then duplicate response to filled tag -> err=1 from the next cycle onward, stream content unaffected.
- Reset mid-run: assert reset with 20 slots outstanding -> all outputs to reset values immediately; a stale response afterwards sets err; fresh traffic then completes correctly.
